// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding and port indices.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } arb_state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input winner selection: fixed priority to port 0, or round-robin against the last grant.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] elig_i,
    input  logic       rr_mode_i,
    input  logic       last_i,
    output logic       winner_o,
    output logic       valid_o
);

    always_comb begin
        valid_o  = |elig_i;
        winner_o = PORT0;
        if (elig_i == 2'b10) begin
            winner_o = PORT1;
        end else if (elig_i == 2'b11 && rr_mode_i) begin
            // Tie in round-robin: the port that was not granted last wins.
            winner_o = (last_i == PORT0) ? PORT1 : PORT0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates two request/ack ports onto one single-port synchronous RAM,
// one access every two cycles (ACCESS then RESP, with back-to-back grants from RESP).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              rr_mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy,
    output logic              gnt_id
);

    arb_state_e        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    logic [1:0] req_vec;
    logic [1:0] ack_mask;
    logic [1:0] elig;
    logic       win_port;
    logic       win_valid;
    logic       take_grant;

    // The port being acked in RESP is masked so it cannot be re-granted on the strength of a stale request.
    assign req_vec  = {req1, req0};
    assign ack_mask = (state_q != ST_RESP) ? 2'b00 : ((gnt_q == PORT1) ? 2'b10 : 2'b01);
    assign elig     = req_vec & ~ack_mask;

    rr_arbiter2 u_arb (
        .elig_i    (elig),
        .rr_mode_i (rr_mode),
        .last_i    (last_q),
        .winner_o  (win_port),
        .valid_o   (win_valid)
    );

    assign take_grant = win_valid && (state_q == ST_IDLE || state_q == ST_RESP);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            ST_IDLE:   state_d = win_valid ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = win_valid ? ST_ACCESS : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (take_grant) begin
            gnt_d   = win_port;
            last_d  = win_port;
            we_d    = (win_port == PORT1) ? we1 : we0;
            addr_d  = (win_port == PORT1) ? addr1 : addr0;
            wdata_d = (win_port == PORT1) ? wdata1 : wdata0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            gnt_q    <= PORT0;
            last_q   <= PORT1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            if (state_q == ST_RESP && !we_q) begin
                if (gnt_q == PORT1) begin
                    rdata1_q <= mem_q;
                end else begin
                    rdata0_q <= mem_q;
                end
            end
        end
    end

    assign ack0 = (state_q == ST_RESP) && (gnt_q == PORT0);
    assign ack1 = (state_q == ST_RESP) && (gnt_q == PORT1);

    // RAM data is forwarded during the ack cycle; the register keeps it afterwards.
    assign rdata0 = (ack0 && !we_q) ? mem_q : rdata0_q;
    assign rdata1 = (ack1 && !we_q) ? mem_q : rdata1_q;

    assign mem_we    = (state_q == ST_ACCESS) && we_q;
    assign mem_addr  = (state_q == ST_ACCESS) ? addr_q : '0;
    assign mem_wdata = mem_we ? wdata_q : '0;
    assign busy      = (state_q != ST_IDLE);
    assign gnt_id    = gnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous RAM.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1, rr_mode;
    logic [15:0] addr0, wdata0, addr1, wdata1;
    logic        ack0, ack1, mem_we, busy, gnt_id;
    logic [15:0] rdata0, rdata1, mem_addr, mem_wdata;
    logic [15:0] mem_q;

    logic        pre_we;
    logic [15:0] pre_addr, pre_data;
    logic [15:0] ram [0:65535];

    int total = 0;
    int bad   = 0;
    logic [15:0] last_rd [2];

    typedef struct packed {
        logic        port;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .ack0      (ack0),
        .rdata0    (rdata0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .ack1      (ack1),
        .rdata1    (rdata1),
        .rr_mode   (rr_mode),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_q     (mem_q),
        .busy      (busy),
        .gnt_id    (gnt_id)
    );

    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_q <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic p, input logic r, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
        if (p) begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_acks"}, {ack1, ack0}, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_gnt"}, gnt_id, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_rdata0"}, rdata0, 0);
        chk({tag, "_rdata1"}, rdata1, 0);
    endtask

    // Both ports hold reads of 0x0010 / 0x0020; grants alternate starting with port 0.
    task automatic contend(input int nk);
        logic exp_port;
        drive(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
        drive(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0);
        for (int k = 1; k <= nk; k++) begin
            @(negedge clk);
            exp_port = 1'(((k - 1) / 2) % 2);
            chk("cont_gnt", gnt_id, exp_port);
            if (k % 2 == 0) begin
                chk("cont_ack", {ack1, ack0}, exp_port ? 2'b10 : 2'b01);
                if (exp_port) chk("cont_rd1", rdata1, 16'h1234);
                else          chk("cont_rd0", rdata0, 16'hBEEF);
                $display("contention cycle %0d rr_mode=%0d ack port %0d", k, rr_mode, exp_port);
            end else begin
                chk("cont_noack", {ack1, ack0}, 0);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        chk("cont_idle", busy, 0);
        last_rd[0] = 16'hBEEF;
        last_rd[1] = 16'h1234;
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        vecs[1] = '{1'b1, 1'b1, 16'h0020, 16'h1234, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234};
        vecs[3] = '{1'b0, 1'b1, 16'h0040, 16'h5A5A, 16'h0000};
        vecs[4] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'h5A5A};
        vecs[5] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        vecs[6] = '{1'b0, 1'b1, 16'hFFFF, 16'h00FF, 16'h0000};
        vecs[7] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h00FF};

        reset = 1'b0;
        rr_mode = 1'b1;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        last_rd[0] = '0;
        last_rd[1] = '0;

        // Preload the RAM while the arbiter is held in reset.
        @(negedge clk); pre_we = 1'b1; pre_addr = 16'h0010; pre_data = 16'hBEEF;
        @(negedge clk); pre_addr = 16'h0030; pre_data = 16'h1111;
        @(negedge clk); pre_we = 1'b0;
        chk_reset_outputs("reset");

        // Request held through reset release is arbitrated on the first edge.
        drive(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        chk("rel_busy", busy, 1);
        chk("rel_addr", mem_addr, 16'h0010);
        chk("rel_noack", {ack1, ack0}, 0);
        @(negedge clk);
        chk("rel_ack", {ack1, ack0}, 2'b01);
        chk("rel_rd0", rdata0, 16'hBEEF);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        chk("rel_idle", busy, 0);
        last_rd[0] = 16'hBEEF;
        $display("txn release-read port 0 addr 0010 rdata0=%h", rdata0);

        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            @(negedge clk);
            drive(v.port, 1'b1, v.we, v.addr, v.wdata);
            @(negedge clk);
            chk("acc_busy", busy, 1);
            chk("acc_gnt", gnt_id, v.port);
            chk("acc_we", mem_we, v.we);
            chk("acc_addr", mem_addr, v.addr);
            chk("acc_noack", {ack1, ack0}, 0);
            if (v.we) chk("acc_wdata", mem_wdata, v.wdata);
            @(negedge clk);
            chk("resp_ack", {ack1, ack0}, v.port ? 2'b10 : 2'b01);
            chk("resp_we", mem_we, 0);
            if (!v.we) last_rd[v.port] = v.exp_rd;
            chk("resp_rd0", rdata0, last_rd[0]);
            chk("resp_rd1", rdata1, last_rd[1]);
            drive(v.port, 1'b0, 1'b0, 16'h0, 16'h0);
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_ack", {ack1, ack0}, 0);
            chk("idle_addr", mem_addr, 0);
            chk("hold_rd0", rdata0, last_rd[0]);
            chk("hold_rd1", rdata1, last_rd[1]);
            $display("txn %0d port %0d we=%0d addr=%h rdata0=%h rdata1=%h",
                     i, v.port, v.we, v.addr, rdata0, rdata1);
        end

        // Round-robin contention: last grant was port 1, so port 0 leads.
        rr_mode = 1'b1;
        @(negedge clk);
        contend(8);

        // Fixed priority: make port 0 the last grant, then a tie in IDLE still goes to port 0.
        rr_mode = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0);
        @(negedge clk);
        @(negedge clk);
        chk("fix_pre_ack", {ack1, ack0}, 2'b01);
        chk("fix_pre_rd0", rdata0, 16'h5A5A);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        chk("fix_pre_idle", busy, 0);
        $display("txn fixed-mode read port 0 addr 0040 rdata0=%h", rdata0);
        contend(6);

        // Reset in the middle of a port 1 write must abort it.
        rr_mode = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 16'h0030, 16'hAAAA);
        @(negedge clk);
        chk("rstw_we", mem_we, 1);
        chk("rstw_gnt", gnt_id, 1);
        #2;
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        chk_reset_outputs("rstw");
        @(negedge clk);
        chk("rstw_ram", ram[16'h0030], 16'h1111);
        chk_reset_outputs("rstw_hold");
        reset = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
        @(negedge clk);
        chk("rstw_noack", {ack1, ack0}, 0);
        chk("rstw_idle", busy, 0);
        $display("txn reset-aborted write port 1 addr 0030 ram=%h", ram[16'h0030]);

        // Port 1 loses the tie and withdraws; it must never be acked.
        drive(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
        drive(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0);
        @(negedge clk);
        chk("wd_gnt", gnt_id, 0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        chk("wd_ack", {ack1, ack0}, 2'b01);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("wd_noack1", ack1, 0);
            chk("wd_idle", busy, 0);
        end
        $display("txn withdrawn request port 1 rdata1=%h", rdata1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
